// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small first-word-fall-through
// byte FIFO drained over a valid/ready handshake.
module uart_rx_fifo #(
  parameter int BIT_CYCLES = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          rx_i,
  output logic [7:0]                    rdata_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CYCLES - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t                     state;
  logic [1:0]                 sync;
  logic                       rx_s;
  logic [CW-1:0]              cnt;
  logic [2:0]                 bit_idx;
  logic [7:0]                 shreg;
  logic                       tick;
  logic                       pop;
  logic                       full;
  logic                       push_ok;
  logic                       push;
  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [AW-1:0]              wptr;
  logic [AW-1:0]              rptr;
  logic [LW-1:0]              level;

  assign rx_s     = sync[1];
  assign tick     = (cnt == '0);
  assign pop      = rvalid_o & rready_i;
  assign full     = (level == DEPTH_L);
  // a pop in the same cycle frees the slot the new byte lands in
  assign push_ok  = ~full | pop;
  assign push     = (state == STOP) & tick & rx_s & push_ok;

  assign rdata_o  = mem[rptr];
  assign rvalid_o = (level != '0);
  assign level_o  = level;

  // two-flop synchronizer; resets to idle-high so reset never looks like a start bit
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) sync <= 2'b11;
    else          sync <= {sync[0], rx_i};
  end

  // frame FSM: bit timing counter, shift register and error/overrun pulses
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= ARM;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (state == START || state == DATA || state == STOP)
        cnt <= tick ? FULL_LOAD : cnt - 1'b1;
      case (state)
        ARM: begin
          if (rx_s) state <= IDLE;
        end
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= HALF_LOAD;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s) begin
              if (!push_ok) overrun_o <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= ARM;
      endcase
    end
  end

  // FIFO storage, wrapping pointers and a separate occupancy counter
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= shreg;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo with a queue-based reference.
module tb_uart_rx_fifo;
  localparam int BC    = 16;
  localparam int DEPTH = 4;
  localparam int H     = BC / 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          rready = 1'b0;
  logic [7:0]    rdata;
  logic          rvalid;
  logic          fe;
  logic          ov;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  uart_rx_fifo #(.BIT_CYCLES(BC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rx_i(rx),
    .rdata_o(rdata), .rvalid_o(rvalid), .rready_i(rready),
    .frame_err_o(fe), .overrun_o(ov), .level_o(level)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rv_cycles = 0;
  int rv_rise = 0;
  logic rv_prev = 1'b0;
  logic [7:0] got[$];
  logic [7:0] acc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // observe handshakes and pulses away from the active edge
  always @(negedge clk) begin
    if (rvalid && rready) got.push_back(rdata);
    if (fe) fe_cnt <= fe_cnt + 1;
    if (ov) ov_cnt <= ov_cnt + 1;
    if (rvalid) begin
      if (!rv_prev) rv_rise <= cyc;
      rv_cycles <= rv_cycles + 1;
    end
    rv_prev <= rvalid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tk(BC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tk(BC);
    end
    rx = stop;
    tk(BC);
  endtask

  task automatic drain();
    rready = 1'b1;
    for (int i = 0; i < 40 && level != '0; i++) tk(1);
    rready = 1'b0;
    tk(2);
    chk("drain_empty", 32'(level), 0);
  endtask

  task automatic check_got(input string tag);
    chk({tag, "_count"}, got.size(), acc.size());
    for (int i = 0; i < acc.size() && i < got.size(); i++) chk(tag, 32'(got[i]), 32'(acc[i]));
    got.delete();
    acc.delete();
  endtask

  initial begin
    int c0, r0, f0, o0, n;
    logic [7:0] b;

    rst_n = 1'b0;
    tk(3);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_fe", 32'(fe), 0);
    chk("rst_ov", 32'(ov), 0);
    rst_n = 1'b1;
    tk(5);

    // single byte, consumer always ready: latency and one-cycle valid
    rready = 1'b1;
    c0 = cyc; r0 = rv_cycles; f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'hA5, 1'b1);
    acc.push_back(8'hA5);
    tk(H + 4);
    chk("a5_rise", rv_rise, c0 + 3 + H + 9 * BC);
    chk("a5_valid_len", rv_cycles - r0, 1);
    check_got("a5_data");
    chk("a5_flags", (fe_cnt - f0) + (ov_cnt - o0), 0);

    // random bytes back-to-back with the consumer ready
    f0 = fe_cnt; o0 = ov_cnt;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      acc.push_back(b);
    end
    tk(BC);
    check_got("rand_stream");
    chk("rand_flags", (fe_cnt - f0) + (ov_cnt - o0), 0);

    // fill past capacity: fifth byte dropped with one overrun
    rready = 1'b0;
    o0 = ov_cnt;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      if (acc.size() < DEPTH) acc.push_back(8'(i));
    end
    tk(BC);
    chk("ovf_level", 32'(level), DEPTH);
    chk("ovf_pulses", ov_cnt - o0, 1);
    chk("ovf_head", 32'(rdata), 1);
    drain();
    check_got("ovf_drain");

    // full FIFO with a pop exactly in the push cycle: no overrun
    o0 = ov_cnt;
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1);
      acc.push_back(8'(i));
    end
    fork
      begin
        repeat (2 + H + 9 * BC) @(posedge clk);
        #1 rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
      end
    join_none
    send_frame(8'h05, 1'b1);
    acc.push_back(8'h05);
    tk(4);
    chk("simul_level", 32'(level), DEPTH);
    chk("simul_head", 32'(rdata), 2);
    chk("simul_ov", ov_cnt - o0, 0);
    drain();
    check_got("simul_drain");

    // random burst sized within capacity
    n = $urandom_range(1, DEPTH);
    o0 = ov_cnt;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      acc.push_back(b);
    end
    tk(BC);
    chk("burst_level", 32'(level), n);
    chk("burst_ov", ov_cnt - o0, 0);
    drain();
    check_got("burst_drain");

    // short low glitch is rejected silently
    rready = 1'b1;
    f0 = fe_cnt; o0 = ov_cnt; r0 = rv_cycles;
    rx = 1'b0;
    tk(3);
    rx = 1'b1;
    tk(20 * BC);
    chk("glitch_bytes", got.size(), 0);
    chk("glitch_valid", rv_cycles - r0, 0);
    chk("glitch_flags", (fe_cnt - f0) + (ov_cnt - o0), 0);
    send_frame(8'h3C, 1'b1);
    acc.push_back(8'h3C);
    tk(BC);
    check_got("after_glitch");

    // bad stop bit followed by a long break: one frame error, no push
    f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h5A, 1'b0);
    tk(40 * BC);
    rx = 1'b1;
    tk(2 * BC);
    chk("break_fe", fe_cnt - f0, 1);
    chk("break_ov", ov_cnt - o0, 0);
    chk("break_bytes", got.size(), 0);
    send_frame(8'h7E, 1'b1);
    acc.push_back(8'h7E);
    tk(BC);
    check_got("after_break");

    // reset during data bit 4 with the line low; buffered byte also lost
    rready = 1'b0;
    send_frame(8'h99, 1'b1);
    tk(2);
    chk("pre_rst_level", 32'(level), 1);
    f0 = fe_cnt; o0 = ov_cnt;
    b = 8'hC3;
    rx = 1'b0;
    tk(BC);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tk(BC);
    end
    rx = b[4];
    tk(H);
    rst_n = 1'b0;
    tk(1);
    rst_n = 1'b1;
    chk("rst_mid_level", 32'(level), 0);
    chk("rst_mid_rvalid", 32'(rvalid), 0);
    tk(3);
    rx = 1'b1;
    tk(20 * BC);
    chk("rst_mid_quiet", 32'(rvalid), 0);
    chk("rst_mid_flags", (fe_cnt - f0) + (ov_cnt - o0), 0);
    got.delete();
    acc.delete();
    rready = 1'b1;
    send_frame(8'hC3, 1'b1);
    acc.push_back(8'hC3);
    tk(BC);
    check_got("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
